// File: rtl/conv_result_streamer_if.sv
// Handshake and data bundle between the conv engine, the result streamer and
// the downstream serial consumer. "master" is the streamer side, "slave" is
// the engine/consumer side that drives done/result_data/m_ready.
interface conv_result_streamer_if #(
  parameter int N_RESULTS = 30,
  parameter int IN_W      = 18,
  parameter int OUT_W     = 8
);
  localparam int IDX_W = $clog2(N_RESULTS);

  logic                           done_signal;
  logic [N_RESULTS-1:0][IN_W-1:0] result_data;
  logic                           m_valid;
  logic                           m_ready;
  logic signed [OUT_W-1:0]        m_data;
  logic [IDX_W-1:0]               m_index;
  logic                           m_last;
  logic                           busy;
  logic                           overrun;
  logic [15:0]                    frame_count;

  modport master (
    input  done_signal, result_data, m_ready,
    output m_valid, m_data, m_index, m_last, busy, overrun, frame_count
  );

  modport slave (
    output done_signal, result_data, m_ready,
    input  m_valid, m_data, m_index, m_last, busy, overrun, frame_count
  );
endinterface

// File: rtl/conv_result_streamer.sv
// Snapshots a row of conv results on done_signal and streams them out one
// quantized sample per handshake (shift, then saturate to OUT_W signed).
// Optional macro RESULT_RELU_EN clamps negative results to zero before quantizing.
module conv_result_streamer #(
  parameter int N_RESULTS = 30,
  parameter int IN_W      = 18,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_result_streamer_if.master bus
);
  localparam int IDX_W = $clog2(N_RESULTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RESULTS - 1);
  localparam logic signed [IN_W-1:0] QMAX = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] QMIN = IN_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state;
  logic [N_RESULTS-1:0][IN_W-1:0] buffer;
  logic [IDX_W-1:0]               idx;
  logic                           overrun_q;
  logic [15:0]                    frame_cnt;

  logic valid;
  logic last;
  logic xfer;
  logic last_xfer;
  logic capture;

  // Quantizer: optional ReLU, arithmetic shift (floor), then clamp to OUT_W.
  function automatic logic signed [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] v;
    logic signed [IN_W-1:0] s;
    v = x;
`ifdef RESULT_RELU_EN
    if (x[IN_W-1]) v = '0;
`else
    v = x;
`endif
    s = v >>> SHIFT;
    if (s > QMAX)      quant = QMAX[OUT_W-1:0];
    else if (s < QMIN) quant = QMIN[OUT_W-1:0];
    else               quant = s[OUT_W-1:0];
  endfunction

  assign valid     = (state == STREAM);
  assign last      = valid && (idx == LAST_IDX);
  assign xfer      = valid && bus.m_ready;
  assign last_xfer = xfer && last;
  // A new row is only accepted when the buffer is free now or frees this edge.
  assign capture   = bus.done_signal && ((state == IDLE) || last_xfer);

  // Stream FSM: capture, index advance, row completion, overrun detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buffer    <= '0;
      idx       <= '0;
      overrun_q <= 1'b0;
      frame_cnt <= '0;
    end else begin
      overrun_q <= bus.done_signal && (state == STREAM) && !last_xfer;
      if (last_xfer) frame_cnt <= frame_cnt + 16'd1;
      if (capture) begin
        buffer <= bus.result_data;
        idx    <= '0;
        state  <= STREAM;
      end else if (last_xfer) begin
        idx   <= '0;
        state <= IDLE;
      end else if (xfer) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.m_valid     = valid;
  assign bus.busy        = valid;
  assign bus.m_last      = last;
  assign bus.m_index     = idx;
  assign bus.m_data      = quant($signed(buffer[idx]));
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_cnt;
endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: ramp, saturation table, random
// back-pressure, overrun, back-to-back rows and mid-stream reset.
// Honours RESULT_RELU_EN when expecting quantized values.
module tb_conv_result_streamer;
  localparam int N = 30;

  typedef logic signed [17:0] row_t  [N];
  typedef logic signed [7:0]  qrow_t [N];

  typedef struct {
    logic signed [17:0] in;
    logic signed [7:0]  exp_q;
    logic signed [7:0]  exp_relu;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fc_exp = 0;

  conv_result_streamer_if #(.N_RESULTS(N), .IN_W(18), .OUT_W(8)) bus ();

  conv_result_streamer #(.N_RESULTS(N), .IN_W(18), .OUT_W(8), .SHIFT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_row(input row_t d);
    for (int k = 0; k < N; k++) bus.result_data[k] = d[k];
  endtask

  // Called at a negedge while idle: one-cycle done pulse.
  task automatic start_row(input row_t d);
    drive_row(d);
    bus.done_signal = 1'b1;
    @(negedge clk);
    bus.done_signal = 1'b0;
  endtask

  // Called at a negedge while streaming. Checks each beat, optionally injects a
  // done at beat inj_at, optionally returns early when idx reaches abort_at.
  task automatic run_row(input qrow_t exp, input bit rnd, input int inj_at,
                         input row_t inj, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int ov_exp = 0;
    while (idx < N && idx != abort_at) begin
      if (cyc > 400) begin
        chk("row_timeout", idx, N);
        break;
      end
      chk("overrun", int'(bus.overrun), ov_exp);
      ov_exp = 0;
      chk("m_valid", int'(bus.m_valid), 1);
      chk("busy", int'(bus.busy), 1);
      chk("m_index", int'(bus.m_index), idx);
      chk("m_data", int'($signed(bus.m_data)), int'(exp[idx]));
      chk("m_last", int'(bus.m_last), (idx == N - 1) ? 1 : 0);
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.done_signal = 1'b0;
      if (idx == inj_at) begin
        bus.m_ready = 1'b1;
        bus.done_signal = 1'b1;
        drive_row(inj);
        if (inj_at != N - 1) ov_exp = 1;
      end
      if (bus.m_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.done_signal = 1'b0;
    if (ov_exp != 0) chk("overrun_tail", int'(bus.overrun), ov_exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(bus.m_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_last"}, int'(bus.m_last), 0);
    chk({tag, "_fc"}, int'(bus.frame_count), fc_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [N];
    row_t  ramp, sat, bp, b2b, none;
    qrow_t ramp_q, sat_q, bp_q, b2b_q;

    // Saturation / rounding table: {input, signed result, ReLU result}.
    tbl[0]  = '{18'sd1000,    8'sd127,  8'sd127};
    tbl[1]  = '{-18'sd1000,  -8'sd128,  8'sd0};
    tbl[2]  = '{18'sd511,     8'sd127,  8'sd127};
    tbl[3]  = '{-18'sd513,   -8'sd128,  8'sd0};
    tbl[4]  = '{-18'sd1,     -8'sd1,    8'sd0};
    tbl[5]  = '{18'sd0,       8'sd0,    8'sd0};
    tbl[6]  = '{18'sd3,       8'sd0,    8'sd0};
    tbl[7]  = '{-18'sd4,     -8'sd1,    8'sd0};
    tbl[8]  = '{18'sd508,     8'sd127,  8'sd127};
    tbl[9]  = '{18'sd512,     8'sd127,  8'sd127};
    tbl[10] = '{-18'sd512,   -8'sd128,  8'sd0};
    tbl[11] = '{-18'sd516,   -8'sd128,  8'sd0};
    tbl[12] = '{18'sd131071,  8'sd127,  8'sd127};
    tbl[13] = '{-18'sd131072,-8'sd128,  8'sd0};
    tbl[14] = '{18'sd4,       8'sd1,    8'sd1};
    tbl[15] = '{-18'sd5,     -8'sd2,    8'sd0};
    tbl[16] = '{18'sd7,       8'sd1,    8'sd1};
    tbl[17] = '{-18'sd8,     -8'sd2,    8'sd0};
    tbl[18] = '{18'sd400,     8'sd100,  8'sd100};
    tbl[19] = '{-18'sd400,   -8'sd100,  8'sd0};
    for (int k = 20; k < N; k++) tbl[k] = '{18'(-4 * k), 8'(-k), 8'sd0};

    for (int k = 0; k < N; k++) begin
      none[k]   = '0;
      ramp[k]   = 18'(4 * k);
      ramp_q[k] = 8'(k);
      sat[k]    = tbl[k].in;
`ifdef RESULT_RELU_EN
      sat_q[k]  = tbl[k].exp_relu;
      bp_q[k]   = (k < 13) ? 8'sd0 : 8'(2 * k - 25);
`else
      sat_q[k]  = tbl[k].exp_q;
      bp_q[k]   = 8'(2 * k - 25);
`endif
      bp[k]     = 18'(8 * k - 100);
      b2b[k]    = 18'(12 * k);
      b2b_q[k]  = 8'(3 * k);
    end

    bus.done_signal = 1'b0;
    bus.m_ready     = 1'b0;
    drive_row(none);

    // Reset values.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_data", int'($signed(bus.m_data)), 0);
    chk("reset_index", int'(bus.m_index), 0);
    chk("reset_overrun", int'(bus.overrun), 0);

    // m_ready while idle is ignored.
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("idle_ready");

    // Ramp with m_ready held high: first sample visible right after capture.
    start_row(ramp);
    run_row(ramp_q, 1'b0, -1, none, -1);
    fc_exp++;
    chk_idle("ramp_end");

    // Saturation table.
    start_row(sat);
    run_row(sat_q, 1'b0, -1, none, -1);
    fc_exp++;
    chk_idle("sat_end");

    // Random back-pressure.
    start_row(bp);
    run_row(bp_q, 1'b1, -1, none, -1);
    fc_exp++;
    chk_idle("bp_end");

    // Overrun: second done at beat 10 is dropped, first row continues.
    start_row(ramp);
    run_row(ramp_q, 1'b0, 10, sat, -1);
    fc_exp++;
    chk_idle("ovr_end");
    chk("ovr_clear", int'(bus.overrun), 0);

    // Back-to-back: done coincident with the last handshake, no bubble.
    start_row(bp);
    run_row(bp_q, 1'b1, N - 1, b2b, -1);
    fc_exp++;
    chk("b2b_fc_mid", int'(bus.frame_count), fc_exp);
    chk("b2b_overrun", int'(bus.overrun), 0);
    run_row(b2b_q, 1'b0, -1, none, -1);
    fc_exp++;
    chk_idle("b2b_end");

    // Reset mid-stream at beat 15.
    start_row(ramp);
    run_row(ramp_q, 1'b0, -1, none, 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fc_exp = 0;
    chk_idle("mid_rst");
    chk("mid_rst_data", int'($signed(bus.m_data)), 0);
    chk("mid_rst_index", int'(bus.m_index), 0);
    chk("mid_rst_overrun", int'(bus.overrun), 0);
    start_row(b2b);
    run_row(b2b_q, 1'b0, -1, none, -1);
    fc_exp++;
    chk_idle("post_rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
